bit_diff_encoder: RTL

Inverse of the bit_diff counter. It takes a signed target difference (ones minus zeros) and serially builds a WIDTH-bit word with exactly that difference, one bit per cycle, LSB first. It sits upstream of the bit_diff/FIFO/multiply-add datapath as a stimulus and round-trip source. Its go/done handshake and latency mirror bit_diff so the two can be chained back to back.

---
 rtl/bit_diff_pkg.sv | 18 +
 rtl/lfsr16.sv | 28 ++
 rtl/bit_diff_encoder.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/bit_diff_pkg.sv
// Shared types and helpers for the bit_diff encoder/counter family.
// Holds the FSM state encoding, the diff-width rule and the LFSR feedback mask.
package bit_diff_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUILD = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Fibonacci taps 16,14,13,11 expressed as a mask over bits [15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int diff_width(input int width);
    return $clog2(2 * width + 1);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR used to scatter ones in bit_diff_encoder.
// Advances one step per enabled cycle; seed must be non-zero to avoid lock-up.
module lfsr16
  import bit_diff_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic out
);

  logic [15:0] r_state;
  logic        w_fb;

  assign w_fb = ^(r_state & LFSR_TAPS);
  assign out  = r_state[15];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SEED;
    end else if (en) begin
      r_state <= {r_state[14:0], w_fb};
    end
  end

endmodule

// File: rtl/bit_diff_encoder.sv
// Serially builds a WIDTH-bit word whose (#ones - #zeros) equals a signed target.
// Optional scattered placement via `define BIT_DIFF_ENCODER_LFSR_EN; default packs ones low.
module bit_diff_encoder
  import bit_diff_pkg::*;
#(
  parameter int          WIDTH     = 32,
  parameter int          DIFF_W    = diff_width(WIDTH),
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     go,
  input  logic signed [DIFF_W-1:0] diff,
  output logic                     ready,
  output logic [WIDTH-1:0]         data,
  output logic                     done,
  output logic                     error
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic signed [DIFF_W:0] W_S  = (DIFF_W + 1)'(WIDTH);
  localparam logic signed [DIFF_W:0] W2_S = (DIFF_W + 1)'(2 * WIDTH);
  localparam logic [CNT_W-1:0]       ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]       FULL = CNT_W'(WIDTH);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_ones_rem;
  logic [CNT_W-1:0]   r_pos_rem;
  logic [WIDTH-1:0]   r_shift;
  logic [WIDTH-1:0]   r_data;
  logic               r_done;
  logic               r_error;

  logic signed [DIFF_W:0] w_diff_ext;
  logic signed [DIFF_W:0] w_sum;
  logic                   w_valid;
  logic [CNT_W-1:0]       w_ones_ld;
  logic                   w_accept;
  logic                   w_last;
  logic                   w_choice;
  logic                   w_bit;
  logic [WIDTH-1:0]       w_shift_nxt;

  // One extra bit keeps diff+WIDTH from wrapping at the range edges
  assign w_diff_ext = {diff[DIFF_W-1], diff};
  assign w_sum      = w_diff_ext + W_S;
  assign w_valid    = (w_sum[DIFF_W] == 1'b0) && (w_sum <= W2_S) && (w_sum[0] == 1'b0);
  assign w_ones_ld  = w_sum[CNT_W:1];

  assign ready    = (r_state == IDLE) || (r_state == DONE);
  assign w_accept = go && ready;
  assign w_last   = (r_pos_rem == ONE);

`ifdef BIT_DIFF_ENCODER_LFSR_EN
  logic w_lfsr_bit;

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (r_state == BUILD),
    .out (w_lfsr_bit)
  );

  assign w_choice = w_lfsr_bit;
`else
  logic w_unused_seed;

  assign w_unused_seed = ^LFSR_SEED;
  assign w_choice      = 1'b1;
`endif

  // Forced ones first, then exhausted ones, then the free choice
  always_comb begin
    w_bit = w_choice;
    if (r_ones_rem == r_pos_rem) begin
      w_bit = 1'b1;
    end else if (r_ones_rem == '0) begin
      w_bit = 1'b0;
    end
  end

  assign w_shift_nxt = {w_bit, r_shift[WIDTH-1:1]};

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE, DONE: begin
        if (go) begin
          w_state_nxt = w_valid ? BUILD : DONE;
        end
      end
      BUILD: begin
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ones_rem <= '0;
      r_pos_rem  <= '0;
      r_shift    <= '0;
      r_data     <= '0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else if (w_accept) begin
      if (w_valid) begin
        r_ones_rem <= w_ones_ld;
        r_pos_rem  <= FULL;
        r_shift    <= '0;
        r_done     <= 1'b0;
        r_error    <= 1'b0;
      end else begin
        r_data  <= '0;
        r_done  <= 1'b1;
        r_error <= 1'b1;
      end
    end else if (r_state == BUILD) begin
      r_shift   <= w_shift_nxt;
      r_pos_rem <= r_pos_rem - ONE;
      if (w_bit) begin
        r_ones_rem <= r_ones_rem - ONE;
      end
      // Publish only the finished word so data never shows a partial build
      if (w_last) begin
        r_data <= w_shift_nxt;
        r_done <= 1'b1;
      end
    end
  end

  assign data  = r_data;
  assign done  = r_done;
  assign error = r_error;

endmodule
